// File: rtl/core_pkg.sv
// Shared types for the instruction/data memory arbiter.
package core_pkg;

    // Arbiter FSM: one memory transaction in flight at a time.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Which requester owns the transaction currently in flight.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection between fetch and data requesters.
// Data wins ties unless its streak has hit the limit, then fetch wins.
module arb_pick (
    input  logic i_req,
    input  logic d_req,
    input  logic streak_max_hit,
    output logic grant_i,
    output logic grant_d
);

    // At most one grant; the tie-break flips only at the streak limit.
    always_comb begin
        grant_i = i_req & (~d_req | streak_max_hit);
        grant_d = d_req & (~i_req | ~streak_max_hit);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises the core's fetch and load/store ports onto one single-port
// memory. IDLE picks a winner and latches its request, REQ holds m_req
// until the memory accepts it, RESP waits for the completion and pulses
// the owner's rvalid before returning to IDLE.
//
// Handshake rules: a requester holds *_req until its *_gnt pulse (gnt is
// combinational in IDLE, same cycle as req); m_req and the m_* fields are
// held stable until the cycle m_gnt=1 and drop on the next cycle; m_rvalid
// is accepted only in RESP, and *_rvalid pulses one cycle after it, so a
// new grant can never coincide with an rvalid pulse.
module mem_arbiter
    import core_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [DW-1:0]   i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            m_req,
    output logic            m_we,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_be,
    input  logic            m_gnt,
    input  logic            m_rvalid,
    input  logic [DW-1:0]   m_rdata,
    output arb_state_t      dbg_state
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);

    arb_state_t    state;
    owner_t        owner;
    logic [SW-1:0] streak;
    logic          streak_max_hit;
    logic          grant_i;
    logic          grant_d;
    logic          rst_q;

    assign streak_max_hit = (streak == SW'(MAX_D_STREAK));

    arb_pick u_pick (
        .i_req          (i_req),
        .d_req          (d_req),
        .streak_max_hit (streak_max_hit),
        .grant_i        (grant_i),
        .grant_d        (grant_d)
    );

    // Grants are only offered from IDLE, and never while reset is applied.
    always_comb begin
        i_gnt     = ~rst & (state == IDLE) & grant_i;
        d_gnt     = ~rst & (state == IDLE) & grant_d;
        dbg_state = state;
    end

    // FSM, latched memory request fields and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= OWN_NONE;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_be     <= '0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            i_rdata  <= '0;
            d_rdata  <= '0;
        end else begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        owner   <= OWN_D;
                        m_req   <= 1'b1;
                        m_we    <= d_we;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                        m_be    <= d_be;
                        state   <= REQ;
                    end else if (grant_i) begin
                        owner   <= OWN_I;
                        m_req   <= 1'b1;
                        m_we    <= 1'b0;
                        m_addr  <= i_addr;
                        m_wdata <= '0;
                        m_be    <= '1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (m_gnt) begin
                        m_req <= 1'b0;
                        state <= RESP;
                    end
                end
                RESP: begin
                    // The rvalid pulse is out this cycle; release the bus.
                    if (i_rvalid || d_rvalid) begin
                        owner <= OWN_NONE;
                        state <= IDLE;
                    end else if (m_rvalid) begin
                        if (owner == OWN_I) begin
                            i_rvalid <= 1'b1;
                            i_rdata  <= m_rdata;
                        end else begin
                            d_rvalid <= 1'b1;
                            d_rdata  <= m_rdata;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Consecutive data grants made while a fetch was waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak <= '0;
        end else if (d_gnt) begin
            if (!i_req)
                streak <= '0;
            else if (!streak_max_hit)
                streak <= streak + SW'(1);
        end else if (i_gnt) begin
            streak <= '0;
        end
    end

    // Delayed reset, so a response already in flight at reset is tolerated.
    always_ff @(posedge clk) begin
        rst_q <= rst;
    end

    // The memory must only complete while a transaction is awaiting it.
    rvalid_only_in_resp: assert property (
        @(posedge clk) disable iff (rst || rst_q)
        !(m_rvalid && (state != RESP))
    );

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int MAXS = 4;

    logic          clk;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [BW-1:0] d_be;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [BW-1:0] m_be;
    logic          m_gnt;
    logic          m_rvalid;
    logic [DW-1:0] m_rdata;
    logic [1:0]    dbg_state;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state: data-streak count and last rdata per port.
    int            m_streak;
    logic [DW-1:0] exp_i_rdata;
    logic [DW-1:0] exp_d_rdata;
    logic [7:0]    exp_q[$];
    logic [7:0]    got_q[$];

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_D_STREAK(MAXS)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_be(d_be), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_be(m_be), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .dbg_state(dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_req = 0; i_addr = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
        m_gnt = 0; m_rvalid = 0; m_rdata = '0;
    endtask

    // One complete transaction: grant, stall, memory latency, response.
    task automatic run_txn(input bit ir, input logic [AW-1:0] ia,
                           input bit dr, input bit dwe, input logic [AW-1:0] da,
                           input logic [DW-1:0] dwd, input logic [BW-1:0] dbe,
                           input int stall, input int lat,
                           input logic [DW-1:0] rd);
        bit            win_i;
        logic          ewe;
        logic [AW-1:0] ea;
        logic [BW-1:0] eb;
        if (ir && dr) win_i = (m_streak >= MAXS);
        else          win_i = ir;
        if (win_i)      m_streak = 0;
        else if (ir)    m_streak = (m_streak + 1 > MAXS) ? MAXS : m_streak + 1;
        else            m_streak = 0;
        ea  = win_i ? ia : da;
        ewe = win_i ? 1'b0 : dwe;
        eb  = win_i ? {BW{1'b1}} : dbe;

        i_req = ir; i_addr = ia;
        d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd; d_be = dbe;
        @(negedge clk);
        got_q.push_back(i_gnt ? 8'h49 : (d_gnt ? 8'h44 : 8'h3f));
        vectors++;
        if ({i_gnt, d_gnt} !== {win_i, ~win_i}) begin
            miscompares++;
            $display("FAIL grant: got i_gnt=%b d_gnt=%b, want %b %b", i_gnt, d_gnt, win_i, ~win_i);
        end
        vectors++;
        if ({m_req, i_rvalid, d_rvalid} !== 3'b000) begin
            miscompares++;
            $display("FAIL grant_cycle_quiet: got m_req/i_rvalid/d_rvalid=%b, want 000", {m_req, i_rvalid, d_rvalid});
        end
        next_cycle();
        if (win_i) i_req = 0; else d_req = 0;

        for (int c = 0; c <= stall; c++) begin
            m_gnt = (c == stall);
            if (c > 0) begin
                // Legal changes from the winner after its grant must not leak.
                if (win_i) i_addr = $urandom(); else d_addr = $urandom();
            end
            @(negedge clk);
            vectors++;
            if ({m_req, m_we, m_addr, m_be, i_gnt, d_gnt} !== {1'b1, ewe, ea, eb, 2'b00}) begin
                miscompares++;
                $display("FAIL req_hold: got req=%b we=%b addr=%h be=%h gnt=%b%b, want 1 %b %h %h 00",
                         m_req, m_we, m_addr, m_be, i_gnt, d_gnt, ewe, ea, eb);
            end
            if (!win_i && dwe) begin
                vectors++;
                if (m_wdata !== dwd) begin
                    miscompares++;
                    $display("FAIL wdata: got %h, want %h", m_wdata, dwd);
                end
            end
            next_cycle();
        end
        m_gnt = 0;

        for (int c = 0; c < lat; c++) begin
            m_rvalid = (c == lat - 1);
            m_rdata  = (c == lat - 1) ? rd : DW'($urandom());
            @(negedge clk);
            vectors++;
            if ({m_req, i_rvalid, d_rvalid, i_gnt, d_gnt} !== 5'b00000) begin
                miscompares++;
                $display("FAIL wait_quiet: got req/irv/drv/ignt/dgnt=%b, want 00000",
                         {m_req, i_rvalid, d_rvalid, i_gnt, d_gnt});
            end
            next_cycle();
        end
        m_rvalid = 0;
        m_rdata  = $urandom();
        if (win_i) exp_i_rdata = rd; else exp_d_rdata = rd;
        @(negedge clk);
        vectors++;
        if ({i_rvalid, d_rvalid, i_gnt, d_gnt} !== {win_i, ~win_i, 2'b00}) begin
            miscompares++;
            $display("FAIL rvalid: got irv=%b drv=%b ignt=%b dgnt=%b, want %b %b 0 0",
                     i_rvalid, d_rvalid, i_gnt, d_gnt, win_i, ~win_i);
        end
        vectors++;
        if ({i_rdata, d_rdata} !== {exp_i_rdata, exp_d_rdata}) begin
            miscompares++;
            $display("FAIL rdata: got i=%h d=%h, want i=%h d=%h", i_rdata, d_rdata, exp_i_rdata, exp_d_rdata);
        end
        next_cycle();
    endtask

    task automatic check_all_zero(input string name);
        vectors++;
        if ({i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
             m_req, m_we, m_addr, m_wdata, m_be} !== '0) begin
            miscompares++;
            $display("FAIL %s: outputs not zero: ignt=%b irv=%b ird=%h dgnt=%b drv=%b drd=%h mreq=%b mwe=%b maddr=%h mwd=%h mbe=%h, want all 0",
                     name, i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
                     m_req, m_we, m_addr, m_wdata, m_be);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        i_req = 1; i_addr = 32'h40; d_req = 1; d_addr = 32'h80;
        repeat (3) next_cycle();
        @(negedge clk);
        check_all_zero("reset_held");
        next_cycle();
        clear_inputs();
        rst = 0;
        @(negedge clk);
        check_all_zero("reset_release");
        next_cycle();
        m_streak = 0; exp_i_rdata = '0; exp_d_rdata = '0;
    endtask

    task automatic test_fetch_only();
        run_txn(1, 32'h100, 0, 0, '0, '0, '0, 0, 2, 32'hDEADBEEF);
    endtask

    task automatic test_priority();
        run_txn(1, 32'h100, 1, 0, 32'h200, '0, '0, 0, 1, 32'hA5A5_0200);
        run_txn(1, 32'h100, 0, 0, '0, '0, '0, 0, 1, 32'hA5A5_0100);
    endtask

    task automatic test_starvation();
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < 10; i++) exp_q.push_back((i % 5 == 4) ? 8'h49 : 8'h44);
        for (int i = 0; i < 10; i++)
            run_txn(1, 32'h1000 + 32'(i * 4), 1, 0, 32'h2000 + 32'(i * 4), '0, '0,
                    0, 1, DW'($urandom()));
        i_req = 0;
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL starve_count: got %0d grants, want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < 10 && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL starve_order[%0d]: got %c, want %c", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_store();
        run_txn(0, '0, 1, 1, 32'h300, 32'h12345678, 4'h3, 0, 2, 32'h0BAD_F00D);
    endtask

    task automatic test_stall();
        run_txn(0, '0, 1, 1, 32'h340, 32'hCAFE_0001, 4'hC, 3, 1, 32'h1111_2222);
        run_txn(1, 32'h380, 0, 0, '0, '0, '0, 3, 3, 32'h3333_4444);
    endtask

    // A fetch that loses, then withdraws before IDLE, receives no grant.
    task automatic test_drop_before_gnt();
        run_txn(1, 32'h500, 1, 0, 32'h600, '0, '0, 1, 1, 32'h5555_6666);
        i_req = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if ({i_gnt, d_gnt, m_req, i_rvalid, d_rvalid} !== 5'b00000) begin
                miscompares++;
                $display("FAIL drop_idle: got ignt/dgnt/mreq/irv/drv=%b, want 00000",
                         {i_gnt, d_gnt, m_req, i_rvalid, d_rvalid});
            end
            next_cycle();
        end
        m_streak = 0;
    endtask

    task automatic test_reset_mid();
        i_req = 1; i_addr = 32'h700;
        @(negedge clk);
        vectors++;
        if (i_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid_grant: got i_gnt=%b, want 1", i_gnt);
        end
        next_cycle();
        i_req = 0; m_gnt = 1;
        next_cycle();
        m_gnt = 0;
        next_cycle();
        rst = 1;
        next_cycle();
        rst = 0; m_rvalid = 1; m_rdata = 32'hFEED_FACE;
        @(negedge clk);
        check_all_zero("rst_mid_after");
        next_cycle();
        m_rvalid = 0;
        @(negedge clk);
        check_all_zero("rst_mid_late_rvalid");
        next_cycle();
        m_streak = 0; exp_i_rdata = '0; exp_d_rdata = '0;
        run_txn(1, 32'h704, 0, 0, '0, '0, '0, 0, 1, 32'h7777_0704);
    endtask

    task automatic test_random();
        bit ip = 0;
        bit dp = 0;
        for (int n = 0; n < 60; n++) begin
            bit ir, dr;
            ir = ip | ($urandom_range(0, 1) == 1);
            dr = dp | ($urandom_range(0, 2) != 0);
            if (!ir && !dr) ir = 1;
            run_txn(ir, $urandom(), dr, $urandom_range(0, 1), $urandom(), $urandom(),
                    BW'($urandom_range(1, 15)), $urandom_range(0, 3),
                    $urandom_range(1, 3), $urandom());
            ip = ir && (got_q[$] != 8'h49);
            dp = dr && (got_q[$] != 8'h44);
        end
        i_req = 0; d_req = 0;
        next_cycle();
        m_streak = 0;
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_priority();
        test_starvation();
        test_store();
        test_stall();
        test_drop_before_gnt();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
